// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receive front end: synchronise, glitch-filter and deserialise
// device-to-host frames, folding E0/F0 prefixes into ext/brk flags on the emitted code.
`timescale 1ns/1ps
module ps2_scan_rx #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          c_s1, c_s2, d_s1, d_s2;
  logic          c_flt;
  logic [FW-1:0] flt_cnt;
  logic          fall_stb;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          ext_flag, brk_flag;
  logic [TW-1:0] to_cnt;
  logic          frame_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagreeing with it;
  // fall_stb is registered so it coincides with the cycle c_flt first reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_flt    <= 1'b1;
      flt_cnt  <= '0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (c_s2 == c_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        c_flt    <= c_s2;
        flt_cnt  <= '0;
        fall_stb <= c_flt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign frame_ok = d_s2 && (^{shreg, par_bit});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ext_flag   <= 1'b0;
      brk_flag   <= 1'b0;
      to_cnt     <= '0;
      code       <= '0;
      code_ext   <= 1'b0;
      code_brk   <= 1'b0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall_stb) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!d_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {d_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= d_s2;
            state   <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!frame_ok) begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end else if (shreg == 8'hE0) begin
              ext_flag <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk_flag <= 1'b1;
            end else begin
              code       <= shreg;
              code_ext   <= ext_flag;
              code_brk   <= brk_flag;
              code_valid <= 1'b1;
              ext_flag   <= 1'b0;
              brk_flag   <= 1'b0;
            end
          end
        endcase
      end else if (state != S_IDLE) begin
        if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          to_cnt    <= '0;
          state     <= S_IDLE;
          frame_err <= 1'b1;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboarded bench for ps2_scan_rx: stimulus queues expected events, a monitor pops them on each strobe.
`timescale 1ns/1ps
module tb_ps2_scan_rx;

  localparam int unsigned TO_CYC = 500;
  localparam time HALF = 2000ns;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] code;
  logic       code_ext, code_brk, code_valid, frame_err;

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;

  ps2_scan_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d),
    .code(code), .code_ext(code_ext), .code_brk(code_brk),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_code(input logic [7:0] c, input logic e, input logic b);
    ev_t ev;
    ev.err = 1'b0; ev.code = c; ev.ext = e; ev.brk = b;
    exp_q.push_back(ev);
  endtask

  task automatic push_err();
    ev_t ev;
    ev = '0;
    ev.err = 1'b1;
    exp_q.push_back(ev);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_flip,
                            input logic stop_val, input int unsigned nbits);
    logic [10:0] f;
    f = {stop_val, (~^data) ^ par_flip, data, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      ps2d = f[i];
      #(HALF);
      ps2c = 1'b0;
      #(HALF);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    #(HALF * 4);
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst && (code_valid || frame_err)) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_event: got valid=%0b err=%0b code=%0h expected no event",
                   code_valid, frame_err, code);
        end else begin
          e = exp_q.pop_front();
          if (e.err) begin
            if (frame_err && !code_valid) n_pass++;
            else $display("FAIL err_event: got valid=%0b err=%0b expected err=1 valid=0",
                          code_valid, frame_err);
          end else begin
            if (code_valid && !frame_err && code == e.code && code_ext == e.ext && code_brk == e.brk)
              n_pass++;
            else $display("FAIL code_event: got valid=%0b err=%0b code=%0h ext=%0b brk=%0b expected code=%0h ext=%0b brk=%0b",
                          code_valid, frame_err, code, code_ext, code_brk, e.code, e.ext, e.brk);
          end
        end
      end
    end
  end

  initial begin : stim
    #20;
    chk("reset_outputs", {code, code_ext, code_brk, code_valid, frame_err}, '0);
    rst = 1'b1;
    #(HALF * 2);

    push_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);

    send_frame(8'hF0, 1'b0, 1'b1, 11);
    push_code(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    push_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);

    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    push_code(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, 11);
    chk("hold_after_e0f075", {code, code_ext, code_brk}, {8'h75, 1'b1, 1'b1});

    push_err();
    send_frame(8'h1C, 1'b1, 1'b1, 11);
    push_err();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    chk("code_kept_after_errs", {24'd0, code}, 32'h75);

    send_frame(8'hF0, 1'b0, 1'b1, 11);
    push_err();
    send_frame(8'h1C, 1'b0, 1'b1, 4);
    #(20ns * TO_CYC * 4);
    push_code(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);

    send_frame(8'hF0, 1'b0, 1'b1, 11);
    send_frame(8'h33, 1'b0, 1'b1, 4);
    rst = 1'b0;
    #100;
    chk("midframe_reset_outputs", {code, code_ext, code_brk, code_valid, frame_err}, '0);
    rst = 1'b1;
    #(HALF * 2);
    push_code(8'h29, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b1, 11);

    @(posedge clk);
    #1 ps2c = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2c = 1'b1;
    repeat (50) @(posedge clk);
    chk("glitch_code_hold", {23'd0, code, code_brk}, {23'd0, 8'h29, 1'b0});

    #(HALF * 4);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
